multicore_system_core_ram_loader: RTL and testbench
===================================================

# multicore_system_core_ram_loader

Stream-to-RAM loader sitting directly upstream of each core's local on-chip RAM (1024 × 32, single-port, Avalon slave s2). It accepts 32-bit words from an inter-core Avalon-ST channel and writes them into consecutive RAM addresses, starting at an address and length programmed by a host over a small CSR slave. It keeps a running checksum and raises a completion interrupt, so the host can preload program/data images into any core without stalling it.

## Interface
- ADDR_W, 10: RAM word-address width (1024 words).
- DATA_W, 32: data width; byteenable width is DATA_W/8.
- clk  in  1  single clock for CSR, stream and RAM master.
- reset_n  in  1  asynchronous, active-low reset.
- csr_address  in  3  CSR word offset.
- csr_chipselect, csr_write, csr_read  in  1  CSR strobes.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data, registered, read latency 1.
- in_data  in  DATA_W  stream word.
- in_valid  in  1  stream word valid.
- in_ready  out  1  loader accepts the word this cycle.
- ram_address  out  ADDR_W  RAM word address.
- ram_byteenable  out  DATA_W/8  always all-ones during a write.
- ram_chipselect, ram_write  out  1  write strobe pair.
- ram_writedata  out  DATA_W  word to write.
- ram_clken  out  1  RAM clock enable, constant 1 after reset.
- irq  out  1  level interrupt = done & irq_en.

## Operation
- CSR map: 0 START (bits[9:0]); 1 LEN (bits[10:0], 0..1024); 2 CTRL (bit0 go, write-1 pulse; bit1 abort, write-1 pulse; bit2 irq_en, R/W); 3 STATUS (bit0 busy RO; bit1 done, sticky, W1C; bit2 aborted, sticky, W1C; bit3 wrapped, sticky, W1C; bits[26:16] words remaining RO); 4 CHECKSUM (RO).
- FSM states: IDLE, RUN.
- IDLE → RUN on go with LEN≠0. On entry: addr←START, remaining←LEN, checksum←0, wrapped←0.
- go with LEN=0: done set immediately, no RAM writes, FSM stays IDLE.
- in_ready = (state==RUN). Acceptance = in_valid & in_ready.
- On each acceptance: issue one RAM write of in_data at addr; addr←addr+1 modulo 1024; checksum←checksum+in_data modulo 2^32; remaining←remaining−1.
- Address 1023→0 sets wrapped.
- Acceptance with remaining=1: RUN → IDLE, done set.
- Abort in RUN: RUN → IDLE, aborted set, done not set. Abort in IDLE is ignored.
- START/LEN writes while busy are ignored. go while busy is ignored.
- Same-cycle rules:
  - Write with go=1 and abort=1: abort wins, no start.
  - Done W1C and done set in the same cycle: set wins.
  - Abort in the same cycle as an acceptance: that word is written, then IDLE.
- Reset values: all outputs 0 except ram_byteenable=0. ram_clken=0 during reset and 1 from the first clock after. State IDLE. All CSR fields 0.

## Timing
- CSR go write in cycle N → busy=1 and in_ready=1 in N+1.
- Word accepted in cycle N → ram_chipselect=ram_write=1 with that address and data in N+1 only (registered, single-cycle strobe).
- Back-to-back acceptance gives one write per cycle; no bubbles are inserted.
- Last acceptance in cycle M:
  - in_ready=0, busy=0, done=1 and irq (if enabled) in M+1.
  - The last RAM write also occurs in M+1.
  - CHECKSUM is final in M+1.
- Abort written in cycle N → in_ready=0 in N+1.
- csr_readdata is valid the cycle after a read strobe and holds its value otherwise.
- Reset asserted mid-RUN: all outputs drop to reset values asynchronously. No partial write strobe survives.

## Structure
- Shared package multicore_system_loader_pkg holds:
  - CSR offsets (REG_START..REG_CHECKSUM),
  - CTRL/STATUS bit positions,
  - the state enum (IDLE, RUN).
- One sub-module, multicore_system_core_ram_loader_csr, contains:
  - register file, W1C/sticky logic, readback mux.
- Top level holds the FSM, address/remaining counters, checksum and RAM output registers.

## Test plan
- START=0x010, LEN=4, stream 0xA0..0xA3 continuous → writes at 0x010..0x013 on consecutive cycles; CHECKSUM=0x286; done=1; irq=1 with irq_en.
- START=0x3FE, LEN=4 → writes at 0x3FE, 0x3FF, 0x000, 0x001; wrapped=1.
- LEN=3, in_valid toggling 1,0,1,0,1 → exactly 3 writes aligned to acceptances; remaining reads 3→0.
- LEN=0, go → done=1 next cycle; no ram_write pulse; busy never set.
- LEN=8, abort after 2 accepted words → exactly 2 writes; in_ready=0 next cycle; aborted=1, done=0; remaining=6.
- reset_n low mid-RUN at word 5 → outputs cleared immediately; after release, state IDLE and all CSRs 0.

Source files
------------

// File: rtl/multicore_system_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multicore_system_loader_pkg
// Purpose  : CSR offsets, CTRL/STATUS bit positions and FSM states shared by
//            the core RAM loader and its CSR block.
// Revision : 1.0
// ============================================================================
package multicore_system_loader_pkg;

  localparam logic [2:0] REG_START    = 3'd0;
  localparam logic [2:0] REG_LEN      = 3'd1;
  localparam logic [2:0] REG_CTRL     = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_CHECKSUM = 3'd4;

  localparam int CTRL_GO      = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IRQ_EN  = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;
  localparam int STAT_WRAPPED = 3;
  localparam int STAT_REM_LSB = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/multicore_system_core_ram_loader_csr.sv
`default_nettype none
// ============================================================================
// Module   : multicore_system_core_ram_loader_csr
// Purpose  : Loader register file: START/LEN/CTRL, sticky W1C status bits and
//            the registered read-back mux.
// Revision : 1.0
// ============================================================================
module multicore_system_core_ram_loader_csr
  import multicore_system_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        csr_address,
  input  logic              csr_chipselect,
  input  logic              csr_write,
  input  logic              csr_read,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  input  logic              busy,
  input  logic [ADDR_W:0]   remaining,
  input  logic [DATA_W-1:0] checksum,
  input  logic              set_done,
  input  logic              set_aborted,
  input  logic              set_wrapped,
  input  logic              clr_wrapped,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W:0]   length,
  output logic              go,
  output logic              abort,
  output logic              irq_en,
  output logic              done
);

  logic              w_wr;
  logic              w_w1c;
  logic [31:0]       w_rdata;
  logic              w_unused;
  logic [ADDR_W-1:0] r_start;
  logic [ADDR_W:0]   r_len;
  logic              r_irq_en;
  logic              r_done;
  logic              r_aborted;
  logic              r_wrapped;
  logic [31:0]       r_readdata;

  assign w_wr     = csr_chipselect & csr_write;
  assign w_w1c    = w_wr & (csr_address == REG_STATUS);
  assign w_unused = &{1'b0, csr_writedata[31:ADDR_W+1]};

  // Abort takes priority over go when both bits are written together.
  assign go    = w_wr & (csr_address == REG_CTRL) & csr_writedata[CTRL_GO]
               & ~csr_writedata[CTRL_ABORT];
  assign abort = w_wr & (csr_address == REG_CTRL) & csr_writedata[CTRL_ABORT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start   <= '0;
      r_len     <= '0;
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      if (w_wr && (csr_address == REG_START) && !busy)
        r_start <= csr_writedata[ADDR_W-1:0];
      if (w_wr && (csr_address == REG_LEN) && !busy)
        r_len <= csr_writedata[ADDR_W:0];
      if (w_wr && (csr_address == REG_CTRL))
        r_irq_en <= csr_writedata[CTRL_IRQ_EN];

      // Hardware set beats a same-cycle W1C.
      if (set_done)
        r_done <= 1'b1;
      else if (w_w1c && csr_writedata[STAT_DONE])
        r_done <= 1'b0;

      if (set_aborted)
        r_aborted <= 1'b1;
      else if (w_w1c && csr_writedata[STAT_ABORTED])
        r_aborted <= 1'b0;

      if (clr_wrapped)
        r_wrapped <= 1'b0;
      else if (set_wrapped)
        r_wrapped <= 1'b1;
      else if (w_w1c && csr_writedata[STAT_WRAPPED])
        r_wrapped <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (csr_address)
      REG_START:    w_rdata[ADDR_W-1:0] = r_start;
      REG_LEN:      w_rdata[ADDR_W:0]   = r_len;
      REG_CTRL:     w_rdata[CTRL_IRQ_EN] = r_irq_en;
      REG_STATUS: begin
        w_rdata[STAT_BUSY]    = busy;
        w_rdata[STAT_DONE]    = r_done;
        w_rdata[STAT_ABORTED] = r_aborted;
        w_rdata[STAT_WRAPPED] = r_wrapped;
        w_rdata[STAT_REM_LSB +: ADDR_W+1] = remaining;
      end
      REG_CHECKSUM: w_rdata = 32'(checksum);
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_readdata <= '0;
    else if (csr_chipselect && csr_read)
      r_readdata <= w_rdata;
  end

  assign csr_readdata = r_readdata;
  assign start_addr   = r_start;
  assign length       = r_len;
  assign irq_en       = r_irq_en;
  assign done         = r_done;

endmodule
`default_nettype wire

// File: rtl/multicore_system_core_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : multicore_system_core_ram_loader
// Purpose  : Writes an Avalon-ST word stream into consecutive local-RAM
//            addresses with running checksum and completion interrupt.
// Revision : 1.0
// ============================================================================
module multicore_system_core_ram_loader
  import multicore_system_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            csr_address,
  input  logic                  csr_chipselect,
  input  logic                  csr_write,
  input  logic                  csr_read,
  input  logic [31:0]           csr_writedata,
  output logic [31:0]           csr_readdata,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_clken,
  output logic                  irq
);

  localparam int            BE_W  = DATA_W / 8;
  localparam logic [ADDR_W:0] C_ONE = (ADDR_W+1)'(1);

  state_e              r_state;
  state_e              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_remaining;
  logic [DATA_W-1:0]   r_checksum;
  logic [ADDR_W-1:0]   r_ram_address;
  logic [BE_W-1:0]     r_ram_byteenable;
  logic                r_ram_write;
  logic                r_ram_chipselect;
  logic [DATA_W-1:0]   r_ram_writedata;
  logic                r_ram_clken;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_last;
  logic                w_start_run;
  logic                w_set_done;
  logic                w_set_aborted;
  logic                w_set_wrapped;
  logic [ADDR_W-1:0]   w_start_addr;
  logic [ADDR_W:0]     w_length;
  logic                w_go;
  logic                w_abort;
  logic                w_irq_en;
  logic                w_done;

  multicore_system_core_ram_loader_csr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_csr (
    .clk            (clk),
    .reset_n        (reset_n),
    .csr_address    (csr_address),
    .csr_chipselect (csr_chipselect),
    .csr_write      (csr_write),
    .csr_read       (csr_read),
    .csr_writedata  (csr_writedata),
    .csr_readdata   (csr_readdata),
    .busy           (w_in_ready),
    .remaining      (r_remaining),
    .checksum       (r_checksum),
    .set_done       (w_set_done),
    .set_aborted    (w_set_aborted),
    .set_wrapped    (w_set_wrapped),
    .clr_wrapped    (w_start_run),
    .start_addr     (w_start_addr),
    .length         (w_length),
    .go             (w_go),
    .abort          (w_abort),
    .irq_en         (w_irq_en),
    .done           (w_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_go && (w_length != '0)) w_next_state = RUN;
      RUN:     if (w_abort || w_last)        w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready    = (r_state == RUN);
    w_accept      = in_valid & w_in_ready;
    w_last        = w_accept & (r_remaining == C_ONE);
    w_start_run   = (r_state == IDLE) & w_go & (w_length != '0);
    // A zero-length go completes on the spot without leaving IDLE.
    w_set_done    = ((r_state == IDLE) & w_go & (w_length == '0))
                  | (w_last & ~w_abort);
    w_set_aborted = (r_state == RUN) & w_abort;
    w_set_wrapped = w_accept & (r_addr == '1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr           <= '0;
      r_remaining      <= '0;
      r_checksum       <= '0;
      r_ram_address    <= '0;
      r_ram_byteenable <= '0;
      r_ram_write      <= 1'b0;
      r_ram_chipselect <= 1'b0;
      r_ram_writedata  <= '0;
      r_ram_clken      <= 1'b0;
    end else begin
      r_ram_clken      <= 1'b1;
      r_ram_byteenable <= '1;
      r_ram_write      <= w_accept;
      r_ram_chipselect <= w_accept;
      if (w_accept) begin
        r_ram_address   <= r_addr;
        r_ram_writedata <= in_data;
      end
      if (w_start_run) begin
        r_addr      <= w_start_addr;
        r_remaining <= w_length;
        r_checksum  <= '0;
      end else if (w_accept) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
        r_checksum  <= r_checksum + in_data;
      end
    end
  end

  assign in_ready       = w_in_ready;
  assign ram_address    = r_ram_address;
  assign ram_byteenable = r_ram_byteenable;
  assign ram_chipselect = r_ram_chipselect;
  assign ram_write      = r_ram_write;
  assign ram_writedata  = r_ram_writedata;
  assign ram_clken      = r_ram_clken;
  assign irq            = w_done & w_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_multicore_system_core_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicore_system_core_ram_loader
// Purpose  : Scenario bench for the core RAM loader with a write scoreboard.
// Revision : 1.0
// ============================================================================
module tb_multicore_system_core_ram_loader;

  localparam logic [2:0] A_START = 3'd0, A_LEN = 3'd1, A_CTRL = 3'd2,
                         A_STATUS = 3'd3, A_CSUM = 3'd4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  csr_address = '0;
  logic        csr_chipselect = 1'b0, csr_write = 1'b0, csr_read = 1'b0;
  logic [31:0] csr_writedata = '0;
  logic [31:0] csr_readdata;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write;
  logic [31:0] ram_writedata;
  logic        ram_clken;
  logic        irq;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [9:0]  exp_addr;
  logic [31:0] exp_sum;
  logic [31:0] rd;

  multicore_system_core_ram_loader #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .csr_address    (csr_address),
    .csr_chipselect (csr_chipselect),
    .csr_write      (csr_write),
    .csr_read       (csr_read),
    .csr_writedata  (csr_writedata),
    .csr_readdata   (csr_readdata),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ram_address    (ram_address),
    .ram_byteenable (ram_byteenable),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_writedata  (ram_writedata),
    .ram_clken      (ram_clken),
    .irq            (irq)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc = cyc + 1; end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Advance to the next falling edge and score any RAM write seen there.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (ram_write || ram_chipselect) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", ram_address, ram_writedata);
      end else begin
        e = q.pop_front();
        if (ram_write !== 1'b1 || ram_chipselect !== 1'b1 || ram_byteenable !== 4'hF ||
            ram_address !== e.addr || ram_writedata !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL ram_write: got we=%b cs=%b be=%h addr=%h data=%h cyc=%0d, required 1 1 f %h %h cyc=%0d",
                   ram_write, ram_chipselect, ram_byteenable, ram_address, ram_writedata, cyc,
                   e.addr, e.data, e.cyc);
        end
      end
    end
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_chipselect = 1'b1; csr_write = 1'b1;
    tick();
    csr_chipselect = 1'b0; csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    csr_address = a; csr_chipselect = 1'b1; csr_read = 1'b1;
    tick();
    csr_chipselect = 1'b0; csr_read = 1'b0;
    d = csr_readdata;
  endtask

  // One stream beat; the model decides whether the word should be taken.
  task automatic drive_beat(input logic v, input logic [31:0] d, input logic exp_ready);
    in_valid = v; in_data = d;
    checks++;
    if (in_ready !== exp_ready) begin
      errors++;
      $display("FAIL in_ready: got %b, required %b", in_ready, exp_ready);
    end
    if (v && exp_ready) begin
      q.push_back('{exp_addr, d, cyc + 1});
      exp_addr = exp_addr + 10'd1;
      exp_sum  = exp_sum + d;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata,
         ram_clken, irq, csr_readdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b addr=%h be=%h cs=%b we=%b wd=%h clken=%b irq=%b rd=%h, required all 0",
               in_ready, ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata,
               ram_clken, irq, csr_readdata);
    end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (ram_clken !== 1'b1) begin
      errors++;
      $display("FAIL reset_clken: got %b, required 1", ram_clken);
    end
    for (int i = 0; i < 5; i++) begin
      csr_rd(3'(i), rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL reset_csr%0d: got %h, required 00000000", i, rd);
      end
    end
  endtask

  task automatic test_basic();
    csr_wr(A_STATUS, 32'hE);
    csr_wr(A_START, 32'h010);
    csr_wr(A_LEN, 32'd4);
    csr_wr(A_CTRL, 32'h5);
    exp_addr = 10'h010; exp_sum = '0;
    for (int i = 0; i < 4; i++) drive_beat(1'b1, 32'hA0 + i, 1'b1);
    checks++;
    if (in_ready !== 1'b0 || irq !== 1'b1) begin
      errors++;
      $display("FAIL basic_end: got rdy=%b irq=%b, required rdy=0 irq=1", in_ready, irq);
    end
    csr_rd(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++;
      $display("FAIL basic_status: got %h, required 00000002", rd);
    end
    csr_rd(A_CSUM, rd);
    checks++;
    if (rd !== 32'h286 || rd !== exp_sum) begin
      errors++;
      $display("FAIL basic_checksum: got %h, required 00000286", rd);
    end
    csr_wr(A_STATUS, 32'h2);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL basic_irq_clear: got %b, required 0", irq);
    end
    csr_rd(A_CTRL, rd);
    checks++;
    if (rd !== 32'h4) begin
      errors++;
      $display("FAIL basic_ctrl: got %h, required 00000004", rd);
    end
  endtask

  task automatic test_wrap();
    csr_wr(A_STATUS, 32'hE);
    csr_wr(A_START, 32'h3FE);
    csr_wr(A_LEN, 32'd4);
    csr_wr(A_CTRL, 32'h1);
    exp_addr = 10'h3FE; exp_sum = '0;
    for (int i = 0; i < 4; i++) drive_beat(1'b1, 32'hB0 + i, 1'b1);
    csr_rd(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0000_000A) begin
      errors++;
      $display("FAIL wrap_status: got %h, required 0000000a", rd);
    end
    csr_rd(A_CSUM, rd);
    checks++;
    if (rd !== exp_sum) begin
      errors++;
      $display("FAIL wrap_checksum: got %h, required %h", rd, exp_sum);
    end
  endtask

  // Status reads form the idle beats of a 1,0,1,0,1 valid pattern.
  task automatic test_toggle();
    logic [31:0] exp_st [3];
    exp_st[0] = 32'h0002_0001; exp_st[1] = 32'h0001_0001; exp_st[2] = 32'h0000_0002;
    csr_wr(A_STATUS, 32'hE);
    csr_wr(A_START, 32'h100);
    csr_wr(A_LEN, 32'd3);
    csr_wr(A_CTRL, 32'h1);
    exp_addr = 10'h100; exp_sum = '0;
    csr_rd(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0003_0001) begin
      errors++;
      $display("FAIL toggle_status_init: got %h, required 00030001", rd);
    end
    for (int i = 0; i < 3; i++) begin
      drive_beat(1'b1, 32'hC0 + i, 1'b1);
      csr_rd(A_STATUS, rd);
      checks++;
      if (rd !== exp_st[i]) begin
        errors++;
        $display("FAIL toggle_status%0d: got %h, required %h", i, rd, exp_st[i]);
      end
    end
  endtask

  task automatic test_len_zero();
    csr_wr(A_STATUS, 32'hE);
    csr_wr(A_START, 32'h050);
    csr_wr(A_LEN, 32'd0);
    csr_wr(A_CTRL, 32'h1);
    csr_rd(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0000_0002) begin
      errors++;
      $display("FAIL len0_status: got %h, required 00000002", rd);
    end
    for (int i = 0; i < 3; i++) drive_beat(1'b1, 32'hDEAD_0000 + i, 1'b0);
  endtask

  task automatic test_abort();
    csr_wr(A_STATUS, 32'hE);
    csr_wr(A_START, 32'h200);
    csr_wr(A_LEN, 32'd8);
    csr_wr(A_CTRL, 32'h1);
    exp_addr = 10'h200; exp_sum = '0;
    csr_wr(A_LEN, 32'd1);
    drive_beat(1'b1, 32'hE0, 1'b1);
    drive_beat(1'b1, 32'hE1, 1'b1);
    csr_wr(A_CTRL, 32'h2);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready: got %b, required 0", in_ready);
    end
    drive_beat(1'b1, 32'hE2, 1'b0);
    csr_rd(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0006_0004) begin
      errors++;
      $display("FAIL abort_status: got %h, required 00060004", rd);
    end
    csr_rd(A_LEN, rd);
    checks++;
    if (rd !== 32'd8) begin
      errors++;
      $display("FAIL abort_len_locked: got %h, required 00000008", rd);
    end
    csr_wr(A_CTRL, 32'h3);
    drive_beat(1'b1, 32'hE3, 1'b0);
    csr_rd(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0006_0004) begin
      errors++;
      $display("FAIL go_abort_status: got %h, required 00060004", rd);
    end
  endtask

  task automatic test_reset_mid_run();
    csr_wr(A_STATUS, 32'hE);
    csr_wr(A_START, 32'h300);
    csr_wr(A_LEN, 32'd8);
    csr_wr(A_CTRL, 32'h5);
    exp_addr = 10'h300; exp_sum = '0;
    for (int i = 0; i < 4; i++) drive_beat(1'b1, 32'hF0 + i, 1'b1);
    in_valid = 1'b1; in_data = 32'hF4;
    @(posedge clk);
    #1;
    checks++;
    if (ram_write !== 1'b1 || ram_address !== 10'h304 || ram_writedata !== 32'hF4) begin
      errors++;
      $display("FAIL mid_run_write: got we=%b addr=%h data=%h, required 1 304 000000f4",
               ram_write, ram_address, ram_writedata);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata,
         ram_clken, irq, csr_readdata} !== '0) begin
      errors++;
      $display("FAIL mid_run_reset: got rdy=%b addr=%h be=%h cs=%b we=%b wd=%h clken=%b irq=%b rd=%h, required all 0",
               in_ready, ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata,
               ram_clken, irq, csr_readdata);
    end
    in_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (ram_clken !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got clken=%b rdy=%b, required 1 0", ram_clken, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      csr_rd(3'(i), rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL post_reset_csr%0d: got %h, required 00000000", i, rd);
      end
    end
  endtask

  initial begin
    exp_addr = '0;
    exp_sum  = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_toggle();
    test_len_zero();
    test_abort();
    test_reset_mid_run();
    repeat (3) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: got %0d pending, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
